// File: rtl/seq_det_pkg.sv
// Shared constants for the programmable serial sequence detector.
package seq_det_pkg;

    // Supported pattern lengths
    localparam int unsigned LEN_MIN = 2;
    localparam int unsigned LEN_MAX = 16;

    // Pattern loaded at reset, matching the legacy fixed "101" detector
    localparam logic [2:0] DEF_PAT_101 = 3'b101;

    // Match-mode encoding for cfg_overlap / ovl
    localparam logic MODE_NONOVL = 1'b0;
    localparam logic MODE_OVL    = 1'b1;

endpackage

// File: rtl/seq_detect_prog_if.sv
// Stream, configuration and status signals of seq_detect_prog.
// master drives the bit stream and configuration; slave is the detector.
interface seq_detect_prog_if #(
    parameter int unsigned LEN   = 3,
    parameter int unsigned CNT_W = 8
);
    logic             x_valid;
    logic             x;
    logic             cfg_load;
    logic [LEN-1:0]   cfg_pattern;
    logic             cfg_overlap;
    logic             z;
    logic             armed;
    logic [CNT_W-1:0] hit_count;

    modport master (
        output x_valid, x, cfg_load, cfg_pattern, cfg_overlap,
        input  z, armed, hit_count
    );

    modport slave (
        input  x_valid, x, cfg_load, cfg_pattern, cfg_overlap,
        output z, armed, hit_count
    );
endinterface

// File: rtl/seq_detect_prog_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count increments, holding once every bit is set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable-pattern serial sequence detector with overlapping and
// non-overlapping modes, a Mealy match pulse and a saturating hit count.
module seq_detect_prog
    import seq_det_pkg::*;
#(
    parameter int unsigned    LEN         = 3,
    parameter logic [LEN-1:0] DEFAULT_PAT = DEF_PAT_101,
    parameter int unsigned    CNT_W       = 8
) (
    input logic               clk,
    input logic               rst,
    seq_detect_prog_if.slave  bus
);

    if (LEN < LEN_MIN || LEN > LEN_MAX) begin : g_len_check
        $error("seq_detect_prog: LEN must lie within LEN_MIN..LEN_MAX");
    end

    localparam int unsigned     FILL_W   = $clog2(LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LEN - 1);
    localparam logic [FILL_W-1:0] FILL_PRE = FILL_W'(LEN - 2);

    logic [LEN-1:0]    pat;
    logic              ovl;
    logic [LEN-2:0]    hist;
    logic [FILL_W-1:0] fill;
    logic              armed_q;
    logic [LEN-1:0]    win;
    logic              accept;
    logic              hit;

    assign win    = {hist, bus.x};
    // A config load in the same cycle swallows the incoming bit
    assign accept = bus.x_valid && !bus.cfg_load;
    assign hit    = accept && armed_q && (win == pat);

    assign bus.z     = hit;
    assign bus.armed = armed_q;

    // Pattern/mode registers and the history/fill window over accepted bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat     <= DEFAULT_PAT;
            ovl     <= MODE_OVL;
            hist    <= '0;
            fill    <= '0;
            armed_q <= 1'b0;
        end else if (bus.cfg_load) begin
            pat     <= bus.cfg_pattern;
            ovl     <= bus.cfg_overlap;
            hist    <= '0;
            fill    <= '0;
            armed_q <= 1'b0;
        end else if (bus.x_valid) begin
            if (hit && (ovl == MODE_NONOVL)) begin
                // Matched bits are consumed; the next match needs LEN fresh bits
                hist    <= '0;
                fill    <= '0;
                armed_q <= 1'b0;
            end else begin
                hist <= win[LEN-2:0];
                if (fill != FILL_MAX) begin
                    fill <= fill + FILL_W'(1);
                end
                // armed mirrors (fill == LEN-1) for the updated fill
                armed_q <= (fill == FILL_MAX) || (fill == FILL_PRE);
            end
        end
    end

    logic [CNT_W-1:0] hit_count;

    sat_counter #(
        .W (CNT_W)
    ) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit),
        .count (hit_count)
    );

    assign bus.hit_count = hit_count;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog: a LEN=3 default instance for the
// functional scenarios and a CNT_W=2 "111" instance for counter saturation.
module tb_seq_detect_prog;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    seq_detect_prog_if #(.LEN(3), .CNT_W(8)) bus ();
    seq_detect_prog_if #(.LEN(3), .CNT_W(2)) sbus ();

    seq_detect_prog #(
        .LEN   (3),
        .CNT_W (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    seq_detect_prog #(
        .LEN         (3),
        .DEFAULT_PAT (3'b111),
        .CNT_W       (2)
    ) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one bit on the main DUT: z checked mid-cycle, state after the edge
    task automatic step(input logic v, input logic b, input logic ez, input logic ea,
                        input int eh, input string tag);
        bus.x_valid = v;
        bus.x       = b;
        @(negedge clk);
        chk({tag, ".z"}, 32'(bus.z), 32'(ez));
        @(posedge clk);
        #1;
        chk({tag, ".armed"}, 32'(bus.armed), 32'(ea));
        chk({tag, ".hits"}, 32'(bus.hit_count), 32'(eh));
        bus.x_valid = 1'b0;
    endtask

    // Configuration load, optionally with a (to be dropped) bit in the same cycle
    task automatic load(input logic [2:0] p, input logic o, input logic v, input logic b,
                        input int eh, input string tag);
        bus.cfg_load    = 1'b1;
        bus.cfg_pattern = p;
        bus.cfg_overlap = o;
        bus.x_valid     = v;
        bus.x           = b;
        @(negedge clk);
        chk({tag, ".z"}, 32'(bus.z), 32'd0);
        @(posedge clk);
        #1;
        bus.cfg_load = 1'b0;
        bus.x_valid  = 1'b0;
        chk({tag, ".armed"}, 32'(bus.armed), 32'd0);
        chk({tag, ".hits"}, 32'(bus.hit_count), 32'(eh));
    endtask

    // Present one bit on the saturation DUT
    task automatic sstep(input logic ez, input int eh, input string tag);
        sbus.x_valid = 1'b1;
        sbus.x       = 1'b1;
        @(negedge clk);
        chk({tag, ".z"}, 32'(sbus.z), 32'(ez));
        @(posedge clk);
        #1;
        chk({tag, ".hits"}, 32'(sbus.hit_count), 32'(eh));
        sbus.x_valid = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b0;
        bus.x_valid = 1'b1; bus.x = 1'b1; bus.cfg_load = 1'b0;
        bus.cfg_pattern = 3'b000; bus.cfg_overlap = 1'b0;
        sbus.x_valid = 1'b0; sbus.x = 1'b0; sbus.cfg_load = 1'b0;
        sbus.cfg_pattern = 3'b000; sbus.cfg_overlap = 1'b0;

        // Reset: even with a valid 1 presented nothing may match
        #3;
        chk("rst.z", 32'(bus.z), 32'd0);
        chk("rst.armed", 32'(bus.armed), 32'd0);
        chk("rst.hits", 32'(bus.hit_count), 32'd0);
        bus.x_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Default 101, overlapping
        step(1, 1, 0, 0, 0, "ovl.b1");
        step(1, 0, 0, 1, 0, "ovl.b2");
        step(1, 1, 1, 1, 1, "ovl.b3");
        step(1, 0, 0, 1, 1, "ovl.b4");
        step(1, 1, 1, 1, 2, "ovl.b5");

        // Non-overlapping 101; count is not cleared by the load
        load(3'b101, 1'b0, 1'b0, 1'b0, 2, "cfg_nov");
        step(1, 1, 0, 0, 2, "nov.b1");
        step(1, 0, 0, 1, 2, "nov.b2");
        step(1, 1, 1, 0, 3, "nov.b3");
        step(1, 0, 0, 0, 3, "nov.b4");
        step(1, 1, 0, 1, 3, "nov.b5");
        step(1, 1, 0, 1, 3, "nov.b6");
        step(1, 0, 0, 1, 3, "nov.b7");
        step(1, 1, 1, 0, 4, "nov.b8");

        // Gated input: idle cycles are invisible, even when x would complete 101
        step(1, 1, 0, 0, 4, "gate.a1");
        step(0, 0, 0, 0, 4, "gate.i1");
        step(1, 0, 0, 1, 4, "gate.a2");
        step(0, 1, 0, 1, 4, "gate.i2");
        step(1, 1, 1, 0, 5, "gate.a3");

        // Reconfigure mid-window; the bit in the load cycle would have matched 101
        step(1, 1, 0, 0, 5, "rcfg.a1");
        step(1, 0, 0, 1, 5, "rcfg.a2");
        load(3'b110, 1'b1, 1'b1, 1'b1, 5, "rcfg.load");
        step(1, 1, 0, 0, 5, "rcfg.b1");
        step(1, 1, 0, 1, 5, "rcfg.b2");
        step(1, 0, 1, 1, 6, "rcfg.b3");

        // Saturation at CNT_W=2 with overlapping 111
        sstep(0, 0, "sat.b1");
        sstep(0, 0, "sat.b2");
        sstep(1, 1, "sat.b3");
        sstep(1, 2, "sat.b4");
        sstep(1, 3, "sat.b5");
        sstep(1, 3, "sat.b6");
        sstep(1, 3, "sat.b7");

        // Asynchronous reset with a live match on z
        step(1, 1, 0, 1, 6, "ar.a1");
        step(1, 1, 0, 1, 6, "ar.a2");
        bus.x_valid = 1'b1;
        bus.x       = 1'b0;
        #2;
        chk("ar.pre.z", 32'(bus.z), 32'd1);
        rst = 1'b0;
        #1;
        chk("ar.z", 32'(bus.z), 32'd0);
        chk("ar.armed", 32'(bus.armed), 32'd0);
        chk("ar.hits", 32'(bus.hit_count), 32'd0);
        bus.x_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        // Pattern is back to the 101 default
        step(1, 1, 0, 0, 0, "ar.b1");
        step(1, 0, 0, 1, 0, "ar.b2");
        step(1, 1, 1, 1, 1, "ar.b3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
